main_mem_responder: RTL
=======================

Name: main_mem_responder

Overview:
- Responder end of the byte-serial main-memory interface driven by the memory controller.
- Accepts one byte request per cycle (address, read/write, write byte):
  - RAM reads return the byte on the next cycle.
  - RAM writes commit at the clock edge.
- A small memory-mapped I/O window provides a buffered byte output port with its own drain handshake, status bytes and a halt flag for simulation and board top levels.

Parameters:
- ADDR_WIDTH, 17, RAM index width; RAM holds 2^ADDR_WIDTH bytes.
- FIFO_DEPTH, 16, output FIFO entries; power of two, 2..256.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- mem_r_w  input  1  0 = read, 1 = write, sampled every cycle.
- mem_addr  input  32  byte address.
- mem_wdata  input  8  write byte.
- mem_rdata  output  8  read byte, registered.
- io_tx_valid  output  1  output FIFO non-empty.
- io_tx_data  output  8  FIFO head byte.
- io_tx_ready  input  1  consumer takes the head byte when high together with io_tx_valid.
- io_full  output  1  FIFO count == FIFO_DEPTH.
- io_drop_cnt  output  8  count of dropped pushes, saturating.
- sim_halt  output  1  sticky halt flag.

Behaviour:
- Every cycle is a request; there is no request/valid strobe.
- Decode:
  - I/O window when mem_addr[17:16] == 2'b11.
  - Otherwise RAM at index mem_addr[ADDR_WIDTH-1:0]; upper address bits are ignored (aliasing).
- RAM read (r_w=0): mem_rdata at edge N+1 = ram[addr] sampled at edge N. Latency is 1 cycle.
- RAM write (r_w=1): ram[addr] <= mem_wdata at the edge. mem_rdata holds its previous value.
- Read of an address written in the immediately preceding cycle returns the new byte.
- RAM contents are not reset.
- I/O writes:
  - 0x30000: push mem_wdata into the FIFO.
  - 0x30004: set sim_halt = 1, sticky until rst.
  - Any other I/O address: ignored.
- I/O reads, with mem_rdata valid next cycle:
  - 0x30000 returns 0x00.
  - 0x30004 returns FIFO count, saturated at 255.
  - 0x30005 returns io_drop_cnt.
  - 0x30008-0x3000B: see optional feature.
  - All other I/O addresses return 0x00.
- FIFO:
  - Circular buffer with head pointer, tail pointer and count; pointers wrap modulo FIFO_DEPTH.
  - Pop when io_tx_valid && io_tx_ready.
  - Push accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is dropped and io_drop_cnt increments, saturating at 0xFF.
  - Simultaneous push and pop: count unchanged and data order preserved.
  - When empty: io_tx_valid = 0, io_tx_data = 0x00, and io_tx_ready is ignored.
- Reset values: mem_rdata 0x00, io_tx_valid 0, io_tx_data 0x00, io_full 0, io_drop_cnt 0, sim_halt 0, FIFO pointers and count 0.
- Reset mid-operation: a write presented in a reset cycle is not committed (neither RAM nor FIFO), and a pending pop is discarded.

Optional Feature:
- Macro IO_CYCLE_COUNTER_EN.
- Defined:
  - A free-running 32-bit cycle counter, reset to 0 and incremented every cycle after reset, wrapping at 2^32.
  - A read of 0x30008 captures the counter into a snapshot register and returns its byte 0.
  - Reads of 0x30009, 0x3000A, 0x3000B return snapshot bytes 1, 2, 3. A 4-byte sequential read is therefore coherent.
- Not defined: no counter or snapshot logic; reads of 0x30008-0x3000B return 0x00.

Decomposition:
- Shared package mem_pkg:
  - I/O base and offset constants: IO_TX 0x30000, IO_STAT 0x30004, IO_DROP 0x30005, IO_CYCLE 0x30008.
  - The I/O select constant 2'b11 on bits [17:16].
- One sub-module, byte_fifo: parameterised depth, push/pop/full/empty/count. The responder owns decode, RAM, status muxing and halt.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 the next cycle → mem_rdata = 0xA5 one cycle after the read address; read of 0x20010 (alias) → 0xA5.
- Write bytes 0x11, 0x22, 0x33 to 0x30000 with io_tx_ready=0, then read 0x30004 → 0x03. Raise io_tx_ready → io_tx_data 0x11, 0x22, 0x33 on consecutive cycles, then io_tx_valid=0.
- Fill FIFO with 16 pushes (io_full=1); a 17th push with ready=0 → dropped, io_drop_cnt=1, read 0x30005 → 0x01. A push with ready=1 while full → accepted, count stays 16.
- Write any byte to 0x30004 → sim_halt=1 next cycle and holds; assert rst → sim_halt=0 and FIFO empty. A write to 0x30000 during rst is not pushed.
- With IO_CYCLE_COUNTER_EN: hold 100 cycles after reset, read 0x30008..0x3000B → bytes assemble the counter value at the 0x30008 read. Without the macro → all 0x00.
- Alternate a read of 0x00020 and a write of 0x7E to 0x00020 on back-to-back cycles → the read after the write returns 0x7E with 1-cycle latency.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and helpers for the main-memory responder.
// Holds the I/O window decode (select bits [17:16] == 2'b11), the I/O
// register offsets and a saturating byte helper used by the status read-back.
package mem_pkg;

  // Address bits [17:16] equal to this value select the I/O window.
  localparam logic [1:0] IO_SEL = 2'b11;

  // I/O register addresses, compared against mem_addr[17:0].
  localparam logic [17:0] IO_TX    = 18'h30000;
  localparam logic [17:0] IO_STAT  = 18'h30004;
  localparam logic [17:0] IO_DROP  = 18'h30005;
  localparam logic [17:0] IO_CYCLE = 18'h30008;

  // Decoded target of one request.
  typedef enum logic [3:0] {
    SEL_RAM,
    SEL_TX,
    SEL_STAT,
    SEL_DROP,
    SEL_CYC0,
    SEL_CYC1,
    SEL_CYC2,
    SEL_CYC3,
    SEL_OTHER
  } io_sel_e;

  // Map the low 18 address bits to a target; only [17:0] matter for decode.
  function automatic io_sel_e decode_addr(input logic [17:0] addr);
    if (addr[17:16] != IO_SEL) return SEL_RAM;
    case (addr)
      IO_TX:          return SEL_TX;
      IO_STAT:        return SEL_STAT;
      IO_DROP:        return SEL_DROP;
      IO_CYCLE:       return SEL_CYC0;
      IO_CYCLE + 18'd1: return SEL_CYC1;
      IO_CYCLE + 18'd2: return SEL_CYC2;
      IO_CYCLE + 18'd3: return SEL_CYC3;
      default:        return SEL_OTHER;
    endcase
  endfunction

  // Clamp a wide count to a status byte.
  function automatic logic [7:0] sat_byte(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with head/tail pointers and an occupancy count.
// Pointers wrap modulo DEPTH (a power of two). A push while full is still
// accepted when a pop happens in the same cycle, so the slot freed by the
// pop is reused and ordering is preserved.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  output logic                       push_ok,
  input  logic                       pop,
  output logic                       valid,
  output logic [7:0]                 head_data,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          empty;
  logic          pop_fire;

  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign valid     = !empty;
  assign count     = cnt;
  // A pop request on an empty FIFO is ignored.
  assign pop_fire  = pop && !empty;
  assign push_ok   = push && (!full || pop_fire);
  assign head_data = empty ? 8'h00 : mem[head];

  // Storage write; nothing is committed during reset.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[tail] <= push_data;
  end

  // Pointer and count bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (pop_fire) head <= head + 1'b1;
      if (push_ok)  tail <= tail + 1'b1;
      case ({push_ok, pop_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/main_mem_responder.sv
// Responder end of the byte-serial main-memory interface.
// Every cycle carries a request (address, r_w, write byte). RAM reads return
// on mem_rdata one cycle later; RAM writes commit at the edge. Addresses with
// bits [17:16] == 2'b11 hit a small I/O window: a buffered byte output port,
// status bytes and a sticky halt flag.
// Optional feature macro: IO_CYCLE_COUNTER_EN adds a free-running 32-bit cycle
// counter readable through a snapshot at 0x30008..0x3000B.
//
// Output port handshake: a byte transfers on a clock edge where io_tx_valid
// and io_tx_ready are both high; io_tx_data is stable while io_tx_valid is
// high and not taken, and io_tx_ready is ignored while io_tx_valid is low.
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_w,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_tx_valid,
  output logic [7:0]  io_tx_data,
  input  logic        io_tx_ready,
  output logic        io_full,
  output logic [7:0]  io_drop_cnt,
  output logic        sim_halt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]            ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_idx;
  io_sel_e               sel;
  logic                  push_req;
  logic                  push_ok;
  logic [CW-1:0]         fifo_count;
  logic [7:0]            rd_next;
  logic                  unused_addr_bits;

  // Upper address bits only alias; they never affect decode.
  assign unused_addr_bits = ^mem_addr[31:18];

  assign sel      = decode_addr(mem_addr[17:0]);
  assign ram_idx  = mem_addr[ADDR_WIDTH-1:0];
  assign push_req = mem_r_w && (sel == SEL_TX);

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (mem_wdata),
    .push_ok   (push_ok),
    .pop       (io_tx_ready),
    .valid     (io_tx_valid),
    .head_data (io_tx_data),
    .full      (io_full),
    .count     (fifo_count)
  );

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;
  logic [31:0] cycle_snap;

  // Free-running cycle counter; a read of the low byte freezes a coherent
  // copy so the following three byte reads come from the same value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt  <= '0;
      cycle_snap <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (!mem_r_w && (sel == SEL_CYC0)) cycle_snap <= cycle_cnt;
    end
  end
`endif

  // RAM write port; contents are not reset and reset-cycle writes are dropped.
  always_ff @(posedge clk) begin
    if (!rst && mem_r_w && (sel == SEL_RAM)) ram[ram_idx] <= mem_wdata;
  end

  // Read data selection for the current request.
  always_comb begin
    rd_next = 8'h00;
    case (sel)
      SEL_RAM:  rd_next = ram[ram_idx];
      SEL_STAT: rd_next = sat_byte(16'(fifo_count));
      SEL_DROP: rd_next = io_drop_cnt;
`ifdef IO_CYCLE_COUNTER_EN
      SEL_CYC0: rd_next = cycle_cnt[7:0];
      SEL_CYC1: rd_next = cycle_snap[15:8];
      SEL_CYC2: rd_next = cycle_snap[23:16];
      SEL_CYC3: rd_next = cycle_snap[31:24];
`endif
      default:  rd_next = 8'h00;
    endcase
  end

  // Registered read data; writes leave the previous value in place.
  always_ff @(posedge clk) begin
    if (rst)           mem_rdata <= 8'h00;
    else if (!mem_r_w) mem_rdata <= rd_next;
  end

  // Saturating count of pushes refused because the FIFO was full.
  always_ff @(posedge clk) begin
    if (rst)                                            io_drop_cnt <= 8'h00;
    else if (push_req && !push_ok && io_drop_cnt != 8'hFF) io_drop_cnt <= io_drop_cnt + 8'd1;
  end

  // Sticky halt flag raised by any write to the status address.
  always_ff @(posedge clk) begin
    if (rst)                                  sim_halt <= 1'b0;
    else if (mem_r_w && (sel == SEL_STAT))    sim_halt <= 1'b1;
  end

endmodule
